// File: rtl/ret_addr_stack.sv
// Return-address stack: push stores pc_in+1, pop discards the top, push+pop replaces the top.
// Latency: ret_addr/count/empty/full update on the edge that performs the operation.
// Backpressure: none; pushes while full and pops while empty are dropped and raise sticky flags.
module ret_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8      // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         ret_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] ret_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    rd_idx;
  logic             we;
  logic             ovf_set;
  logic             unf_set;

  assign pc_inc = pc_in + WIDTH'(1);
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  // Entry below the top, i.e. the new top after a pop with two or more entries.
  assign rd_idx = AW'(cnt - CW'(2));

  // Decode {push,pop} into next count, next ret_addr, RAM write and flag sets.
  always_comb begin
    cnt_nxt = cnt;
    ret_nxt = ret_addr;
    we      = 1'b0;
    waddr   = cnt[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (!full) begin
          we      = 1'b1;
          cnt_nxt = cnt + CW'(1);
          ret_nxt = pc_inc;
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (cnt > CW'(1)) begin
          cnt_nxt = cnt - CW'(1);
          ret_nxt = mem[rd_idx];
        end else if (cnt == CW'(1)) begin
          cnt_nxt = '0;
          ret_nxt = '0;
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        // Tail call: overwrite the top; on an empty stack this is a plain push.
        we      = 1'b1;
        ret_nxt = pc_inc;
        if (empty) begin
          cnt_nxt = CW'(1);
        end else begin
          waddr = AW'(cnt - CW'(1));
        end
      end
      default: ;
    endcase
  end

  // Entry RAM has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[waddr] <= pc_inc;
    end
  end

  // Count, registered top copy and sticky error flags (clear wins over set).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      ret_addr  <= ret_nxt;
      overflow  <= clr_err ? 1'b0 : (overflow  | ovf_set);
      underflow <= clr_err ? 1'b0 : (underflow | unf_set);
    end
  end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: queue-based reference model checked every cycle plus directed literals.
// Latency: model updates on the same edge as the DUT; compare happens on the falling edge.
// Backpressure: none; stimulus drives one operation per cycle.
module tb_ret_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [15:0] pc_in = '0;
  logic        clr_err = 1'b0;
  logic [15:0] ret_addr;
  logic [3:0]  count;
  logic        empty, full, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  ret_addr_stack #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pc_in(pc_in),
    .clr_err(clr_err), .ret_addr(ret_addr), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack is a queue, the top is its last element.
  logic [15:0] m_stk[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit so, su;
    so = 1'b0;
    su = 1'b0;
    if (!rst_n) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      case ({push, pop})
        2'b10: if (m_stk.size() < 8) m_stk.push_back(pc_in + 16'd1); else so = 1'b1;
        2'b01: if (m_stk.size() > 0) void'(m_stk.pop_back()); else su = 1'b1;
        2'b11: if (m_stk.size() > 0) m_stk[m_stk.size()-1] = pc_in + 16'd1;
               else m_stk.push_back(pc_in + 16'd1);
        default: ;
      endcase
      m_ovf = clr_err ? 1'b0 : (m_ovf | so);
      m_unf = clr_err ? 1'b0 : (m_unf | su);
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      logic [15:0] m_top;
      m_top = (m_stk.size() == 0) ? 16'h0000 : m_stk[$];
      chk("m_ret_addr",  32'(ret_addr),  32'(m_top));
      chk("m_count",     32'(count),     32'(m_stk.size()));
      chk("m_empty",     32'(empty),     32'(m_stk.size() == 0));
      chk("m_full",      32'(full),      32'(m_stk.size() == 8));
      chk("m_overflow",  32'(overflow),  32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // One operation per cycle: drive after the falling edge, release after the rising edge.
  task automatic op(input logic p, input logic q, input logic [15:0] pc, input logic c);
    @(negedge clk);
    push = p; pop = q; pc_in = pc; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    started = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ret", 32'(ret_addr), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_flags", 32'({overflow, underflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single push
    op(1, 0, 16'h0010, 0);
    chk("t1_ret", 32'(ret_addr), 32'h0011);
    chk("t1_count", 32'(count), 1);
    chk("t1_empty", 32'(empty), 0);
    op(0, 1, 16'h0000, 0);
    chk("t1_pop_empty", 32'(empty), 1);

    // 2: LIFO order
    op(1, 0, 16'h0100, 0);
    op(1, 0, 16'h0200, 0);
    op(1, 0, 16'h0300, 0);
    chk("t2_ret0", 32'(ret_addr), 32'h0301);
    op(0, 1, 16'h0000, 0);
    chk("t2_ret1", 32'(ret_addr), 32'h0201);
    op(0, 1, 16'h0000, 0);
    chk("t2_ret2", 32'(ret_addr), 32'h0101);
    op(0, 1, 16'h0000, 0);
    chk("t2_empty", 32'(empty), 1);
    chk("t2_ret_end", 32'(ret_addr), 0);

    // 3: fill, overflow, clear, clear-beats-set, replace while full
    for (int i = 0; i < 8; i++) op(1, 0, 16'h1000 + 16'(i), 0);
    op(1, 0, 16'h2000, 0);
    chk("t3_full", 32'(full), 1);
    chk("t3_count", 32'(count), 8);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_top", 32'(ret_addr), 32'h1008);
    op(0, 0, 16'h0000, 1);
    chk("t3_clr", 32'(overflow), 0);
    op(1, 0, 16'h2000, 1);
    chk("t3_clr_prio", 32'(overflow), 0);
    op(1, 1, 16'h3000, 0);
    chk("t3_repl_full_ret", 32'(ret_addr), 32'h3001);
    chk("t3_repl_full_ovf", 32'(overflow), 0);
    chk("t3_repl_full_cnt", 32'(count), 8);
    for (int i = 0; i < 7; i++) op(0, 1, 16'h0000, 0);
    chk("t3_bottom", 32'(ret_addr), 32'h1001);
    op(0, 1, 16'h0000, 0);
    chk("t3_drained", 32'(count), 0);

    // 4: underflow, replace on empty with wrap
    op(0, 1, 16'h0000, 0);
    chk("t4_unf", 32'(underflow), 1);
    chk("t4_count", 32'(count), 0);
    chk("t4_ret", 32'(ret_addr), 0);
    op(1, 1, 16'hFFFF, 0);
    chk("t4_wrap_cnt", 32'(count), 1);
    chk("t4_wrap_ret", 32'(ret_addr), 32'h0000);
    chk("t4_wrap_empty", 32'(empty), 0);
    op(0, 0, 16'h0000, 1);
    chk("t4_clr", 32'(underflow), 0);

    // 5: replace with three entries, then pop exposes the second entry
    op(1, 0, 16'h0A00, 0);
    op(1, 0, 16'h0B00, 0);
    op(1, 1, 16'h0AB0, 0);
    chk("t5_cnt", 32'(count), 3);
    chk("t5_ret", 32'(ret_addr), 32'h0AB1);
    op(0, 1, 16'h0000, 0);
    chk("t5_second", 32'(ret_addr), 32'h0A01);
    chk("t5_cnt2", 32'(count), 2);

    // 6: asynchronous reset in the middle of a push cycle
    @(negedge clk);
    push = 1'b1; pc_in = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cnt", 32'(count), 0);
    chk("t6_async_ret", 32'(ret_addr), 0);
    chk("t6_async_empty", 32'(empty), 1);
    @(posedge clk);
    #1 push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_post_cnt", 32'(count), 0);
    chk("t6_post_ret", 32'(ret_addr), 0);
    op(1, 0, 16'h0001, 0);
    chk("t6_push_ret", 32'(ret_addr), 32'h0002);
    op(0, 1, 16'h0000, 0);
    chk("t6_pop_ret", 32'(ret_addr), 0);
    chk("t6_pop_cnt", 32'(count), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
